// File: rtl/sdi_ctrl_pkg.sv
// Shared definitions for the SDI mode-switch sequencer.
// Contents: state encoding, video mode codes, timeout counter width and
// the lock blanking interval used while a PLL reconfiguration settles.
package sdi_ctrl_pkg;

  localparam int TMO_W             = 23;
  localparam int LOCK_BLANK_CYCLES = 16;

  localparam logic [2:0] MODE_1080P24 = 3'd0;
  localparam logic [2:0] MODE_1080P25 = 3'd1;
  localparam logic [2:0] MODE_1080P30 = 3'd2;
  localparam logic [2:0] MODE_1080P50 = 3'd3;
  localparam logic [2:0] MODE_1080P60 = 3'd4;
  localparam logic [2:0] MODE_MAX     = MODE_1080P60;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_EOF  = 3'd1,
    ST_DISABLE   = 3'd2,
    ST_RECONFIG  = 3'd3,
    ST_WAIT_LOCK = 3'd4,
    ST_SETTLE    = 3'd5,
    ST_ENABLE    = 3'd6,
    ST_FAULT     = 3'd7
  } state_t;

  function automatic logic mode_valid(input logic [2:0] mode);
    return (mode <= MODE_MAX);
  endfunction

endpackage

// File: rtl/sdi_tmo_counter.sv
// Loadable down-counter with zero flag, shared by every timed state of the
// SDI mode-switch sequencer.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load, i_val  : load strobe and load value (load wins over counting)
//   o_cnt          : current count, stops at zero
//   o_zero         : count is zero
module sdi_tmo_counter
  import sdi_ctrl_pkg::*;
#(
  parameter int W = TMO_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sdi_mode_switch_ctrl.sv
// SDI mode-switch sequencer: owns the frame generator mode/enable and the
// reference-clock reconfiguration request. Runs the power-on bring-up
// (starts in RECONFIG with DEFAULT_MODE) and host-requested mode changes
// (frame boundary -> disable -> reconfig -> lock -> settle -> enable).
// Optional build macro: SDI_MODE_STATUS_EN adds o_switch_cnt and o_state.
// Ports:
//   i_clk, i_rst_n                 : clock, asynchronous active-low reset
//   i_mode_req, i_mode_req_vld     : mode request and strobe
//   o_mode_req_rdy / o_mode_rej    : ready (IDLE only) / invalid-mode pulse
//   i_sdi_fval                     : frame valid from frame generator
//   i_pll_locked                   : reference PLL lock (synchronised)
//   o_pll_reconfig, o_pll_sel      : reconfig pulse and mode for the PLL
//   o_video_mode, o_sdi_enable     : frame generator mode and enable
//   o_busy, o_err, i_err_clr       : busy, sticky error, error clear
//   o_switch_cnt, o_state          : (SDI_MODE_STATUS_EN) status taps
module sdi_mode_switch_ctrl
  import sdi_ctrl_pkg::*;
#(
  parameter logic [2:0] DEFAULT_MODE  = MODE_1080P30,
  parameter int         SETTLE_CYCLES = 1024,
  parameter int         LOCK_TIMEOUT  = 1048576,
  parameter int         EOF_TIMEOUT   = 4194304,
  parameter int         MAX_RETRY     = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_mode_req,
  input  logic       i_mode_req_vld,
  output logic       o_mode_req_rdy,
  output logic       o_mode_rej,
  input  logic       i_sdi_fval,
  input  logic       i_pll_locked,
  output logic       o_pll_reconfig,
  output logic [2:0] o_pll_sel,
  output logic [2:0] o_video_mode,
  output logic       o_sdi_enable,
  output logic       o_busy,
  output logic       o_err,
  input  logic       i_err_clr
`ifdef SDI_MODE_STATUS_EN
  ,
  output logic [15:0] o_switch_cnt,
  output logic [2:0]  o_state
`endif
);

  // Cycles each timed state may last. One lock attempt, including the
  // RECONFIG cycle, spans LOCK_BLANK_CYCLES + LOCK_TIMEOUT cycles.
  localparam logic [TMO_W-1:0] EOF_LEN    = TMO_W'(EOF_TIMEOUT);
  localparam logic [TMO_W-1:0] LOCK_LEN   = TMO_W'(LOCK_BLANK_CYCLES + LOCK_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] SETTLE_LEN = TMO_W'(SETTLE_CYCLES);
  // Counter values above this threshold fall in the lock blanking window.
  localparam logic [TMO_W-1:0] BLANK_THR  = TMO_W'(LOCK_TIMEOUT - 2);

  // The counter is loaded during the first cycle of a state and counts from
  // the second, so a state lasting len cycles loads len-2.
  function automatic logic [TMO_W-1:0] tmo_preload(input logic [TMO_W-1:0] len);
    return (len >= TMO_W'(2)) ? (len - TMO_W'(2)) : '0;
  endfunction

  state_t           r_state;
  state_t           r_prev_state;
  logic [2:0]       r_pending;
  logic [2:0]       r_video_mode;
  logic [2:0]       r_pll_sel;
  logic             r_sdi_enable;
  logic             r_pll_reconfig;
  logic             r_mode_rej;
  logic             r_err;
  logic [7:0]       r_retry;
  logic             r_fval_q;
`ifdef SDI_MODE_STATUS_EN
  logic [15:0]      r_switch_cnt;
`endif

  logic             w_tmo_load;
  logic [TMO_W-1:0] w_tmo_len;
  logic [TMO_W-1:0] w_tmo_cnt;
  logic             w_tmo_zero;
  logic             w_tmo_done;
  logic             w_lock_blank;
  logic             w_fval_fall;

  always_comb begin
    w_tmo_len = '0;
    case (r_state)
      ST_WAIT_EOF:  w_tmo_len = EOF_LEN;
      ST_WAIT_LOCK: w_tmo_len = LOCK_LEN;
      ST_SETTLE:    w_tmo_len = SETTLE_LEN;
      default:      w_tmo_len = '0;
    endcase
  end

  // State entry is the cycle where the state differs from the previous one.
  assign w_tmo_load   = (r_state != r_prev_state);
  assign w_tmo_done   = w_tmo_load ? (w_tmo_len <= TMO_W'(1)) : w_tmo_zero;
  assign w_lock_blank = w_tmo_load || (w_tmo_cnt > BLANK_THR);
  assign w_fval_fall  = r_fval_q && !i_sdi_fval;

  sdi_tmo_counter #(
    .W (TMO_W)
  ) u_tmo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_tmo_load),
    .i_val   (tmo_preload(w_tmo_len)),
    .o_cnt   (w_tmo_cnt),
    .o_zero  (w_tmo_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= ST_RECONFIG;
      r_prev_state   <= ST_IDLE;
      r_pending      <= DEFAULT_MODE;
      r_video_mode   <= DEFAULT_MODE;
      r_pll_sel      <= DEFAULT_MODE;
      r_sdi_enable   <= 1'b0;
      r_pll_reconfig <= 1'b0;
      r_mode_rej     <= 1'b0;
      r_err          <= 1'b0;
      r_retry        <= '0;
      r_fval_q       <= 1'b0;
`ifdef SDI_MODE_STATUS_EN
      r_switch_cnt   <= '0;
`endif
    end else begin
      r_prev_state   <= r_state;
      r_fval_q       <= i_sdi_fval;
      r_pll_reconfig <= 1'b0;
      r_mode_rej     <= 1'b0;
      // A timeout assignment further down overrides this clear.
      if (i_err_clr) r_err <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (!i_pll_locked) begin
            r_sdi_enable <= 1'b0;
            r_pending    <= r_video_mode;
            r_retry      <= '0;
            r_state      <= ST_WAIT_LOCK;
          end else if (i_mode_req_vld) begin
            if (!mode_valid(i_mode_req)) begin
              r_mode_rej <= 1'b1;
            end else if (i_mode_req != r_video_mode) begin
              r_pending <= i_mode_req;
              r_state   <= ST_WAIT_EOF;
            end
          end
        end
        ST_WAIT_EOF: begin
          if (w_fval_fall || w_tmo_done) begin
            r_sdi_enable <= 1'b0;
            r_state      <= ST_DISABLE;
          end
        end
        ST_DISABLE: begin
          r_state <= ST_RECONFIG;
        end
        ST_RECONFIG: begin
          r_pll_sel      <= r_pending;
          r_pll_reconfig <= 1'b1;
          r_retry        <= r_retry + 8'd1;
          r_state        <= ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (!w_lock_blank && i_pll_locked) begin
            r_state <= ST_SETTLE;
          end else if (w_tmo_done) begin
            r_err   <= 1'b1;
            r_state <= (r_retry < 8'(MAX_RETRY)) ? ST_RECONFIG : ST_FAULT;
          end
        end
        ST_SETTLE: begin
          // Lock loss re-enters WAIT_LOCK without a new reconfig attempt.
          if (!i_pll_locked) begin
            r_state <= ST_WAIT_LOCK;
          end else if (w_tmo_done) begin
            r_video_mode <= r_pending;
            r_state      <= ST_ENABLE;
          end
        end
        ST_ENABLE: begin
          r_sdi_enable <= 1'b1;
          r_retry      <= '0;
          r_state      <= ST_IDLE;
`ifdef SDI_MODE_STATUS_EN
          r_switch_cnt <= r_switch_cnt + 16'd1;
`endif
        end
        ST_FAULT: begin
          r_sdi_enable <= 1'b0;
          if (i_err_clr) begin
            r_retry <= '0;
            r_state <= ST_RECONFIG;
          end
        end
        default: r_state <= ST_RECONFIG;
      endcase
    end
  end

  assign o_mode_req_rdy = (r_state == ST_IDLE);
  assign o_busy         = (r_state != ST_IDLE);
  assign o_mode_rej     = r_mode_rej;
  assign o_pll_reconfig = r_pll_reconfig;
  assign o_pll_sel      = r_pll_sel;
  assign o_video_mode   = r_video_mode;
  assign o_sdi_enable   = r_sdi_enable;
  assign o_err          = r_err;
`ifdef SDI_MODE_STATUS_EN
  assign o_switch_cnt   = r_switch_cnt;
  assign o_state        = r_state;
`endif

endmodule
